// File: rtl/ui_pkg.sv
// Shared screen-state encoding and sprite geometry for the UI sequencer and sprite modules.
// Latency: none (types and constants only).
// Backpressure: none.
package ui_pkg;

    typedef enum logic [1:0] {
        TITLE         = 2'd0,
        FILTER_SELECT = 2'd1,
        CONFIRM       = 2'd2,
        RUN           = 2'd3
    } screen_state_t;

    // Pixel BROM latency: image BROM (2) followed by palette BROM (2).
    localparam int UI_LAT            = 4;
    localparam int UI_SPRITE_W       = 900;
    localparam int UI_SPRITE_H       = 24;
    localparam int UI_SPRITE_X       = 190;   // (1280 - 900) / 2, centred
    localparam int UI_SPRITE_Y       = 680;
    localparam int UI_NUM_FILTERS    = 4;
    localparam int UI_BLINK_FRAMES   = 30;
    localparam int UI_TIMEOUT_FRAMES = 600;

    // Half-open span test [lo, lo+len). Everything is 12 bits wide so lo+len
    // (1090 for the default sprite) never overflows.
    function automatic logic in_span(input logic [11:0] pos,
                                     input logic [11:0] lo,
                                     input logic [11:0] len);
        return (pos >= lo) && (pos < (lo + len));
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register used to align side-band bits with BROM read data.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; advances every cycle, synchronous reset flushes all stages.
module pipe_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per cycle; reset clears the whole pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ui_screen_sequencer.sv
// UI screen FSM (title/filter select/confirm/run) with frame-aligned commits and sprite pixel gating.
// Latency: state changes at the new_frame edge; pixel_out is LAT+1 cycles after its hcount/vcount.
// Backpressure: none; button pulses are held pending until the next frame start, one action per frame.
module ui_screen_sequencer
    import ui_pkg::*;
#(
    parameter int LAT            = UI_LAT,
    parameter int SPRITE_W       = UI_SPRITE_W,
    parameter int SPRITE_H       = UI_SPRITE_H,
    parameter int SPRITE_X       = UI_SPRITE_X,
    parameter int SPRITE_Y       = UI_SPRITE_Y,
    parameter int NUM_FILTERS    = UI_NUM_FILTERS,
    parameter int BLINK_FRAMES   = UI_BLINK_FRAMES,
    parameter int TIMEOUT_FRAMES = UI_TIMEOUT_FRAMES
) (
    input  logic                           pixel_clk_in,
    input  logic                           rst_in,
    input  logic [10:0]                    hcount_in,
    input  logic [9:0]                     vcount_in,
    input  logic                           new_frame_in,
    input  logic                           btn_next_pulse_in,
    input  logic                           btn_back_pulse_in,
    input  logic                           btn_sel_pulse_in,
    input  logic [11:0]                    sprite_pixel_in,
    output logic [1:0]                     sprite_sel_out,
    output logic [10:0]                    sprite_x_out,
    output logic [9:0]                     sprite_y_out,
    output logic [1:0]                     screen_state_out,
    output logic [$clog2(NUM_FILTERS)-1:0] filter_idx_out,
    output logic                           filter_valid_out,
    output logic [11:0]                    pixel_out
);

    localparam int IDX_W = $clog2(NUM_FILTERS);
    localparam int TO_W  = $clog2(TIMEOUT_FRAMES);
    localparam int BL_W  = $clog2(BLINK_FRAMES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FILTERS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_FRAMES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_FRAMES - 1);
    localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);

    screen_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [BL_W-1:0]  bl_cnt_q, bl_cnt_d;
    logic             phase_q, phase_d;

    logic next_pend_q, back_pend_q, sel_pend_q;
    logic next_req, back_req, sel_req;
    logic do_next, do_back, do_sel;

    logic        win, win_dly;
    logic [11:0] pixel_q;

    // A pulse landing on the frame-start cycle counts for this frame.
    assign next_req = next_pend_q | btn_next_pulse_in;
    assign back_req = back_pend_q | btn_back_pulse_in;
    assign sel_req  = sel_pend_q  | btn_sel_pulse_in;

    // Exactly one action per frame: back beats sel beats next.
    assign do_back = new_frame_in & back_req;
    assign do_sel  = new_frame_in & ~back_req & sel_req;
    assign do_next = new_frame_in & ~back_req & ~sel_req & next_req;

    // Hold presses until the frame start consumes them; all flags drop together.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in || new_frame_in) begin
            next_pend_q <= 1'b0;
            back_pend_q <= 1'b0;
            sel_pend_q  <= 1'b0;
        end else begin
            next_pend_q <= next_req;
            back_pend_q <= back_req;
            sel_pend_q  <= sel_req;
        end
    end

    // Screen state, filter selection, confirm timeout and blink registers.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q  <= TITLE;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            to_cnt_q <= '0;
            bl_cnt_q <= '0;
            phase_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            to_cnt_q <= to_cnt_d;
            bl_cnt_q <= bl_cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Next-state logic; only evaluated at frame start so the screen never tears.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        to_cnt_d = to_cnt_q;
        bl_cnt_d = bl_cnt_q;
        phase_d  = phase_q;
        if (new_frame_in) begin
            case (state_q)
                TITLE: begin
                    if (do_sel) state_d = FILTER_SELECT;
                end
                FILTER_SELECT: begin
                    if (do_sel) begin
                        state_d  = CONFIRM;
                        to_cnt_d = '0;
                        bl_cnt_d = '0;
                        phase_d  = 1'b1;
                    end else if (do_back) begin
                        idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_ONE;
                    end else if (do_next) begin
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
                    end
                end
                CONFIRM: begin
                    if (do_sel) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end else if (do_back) begin
                        state_d = FILTER_SELECT;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = FILTER_SELECT;
                    end else begin
                        // Still waiting: age the timeout and run the blink.
                        to_cnt_d = to_cnt_q + TO_ONE;
                        if (bl_cnt_q == BL_LAST) begin
                            bl_cnt_d = '0;
                            phase_d  = ~phase_q;
                        end else begin
                            bl_cnt_d = bl_cnt_q + BL_ONE;
                        end
                    end
                end
                RUN: begin
                    if (do_back) begin
                        state_d = FILTER_SELECT;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = TITLE;
            endcase
        end
        // Sprite is steady outside CONFIRM.
        if (state_d != CONFIRM) phase_d = 1'b1;
    end

    assign win = in_span({1'b0, hcount_in}, 12'(SPRITE_X), 12'(SPRITE_W)) &&
                 in_span({2'b0, vcount_in}, 12'(SPRITE_Y), 12'(SPRITE_H));

    pipe_delay #(
        .DEPTH (LAT),
        .WIDTH (1)
    ) u_win_dly (
        .clk  (pixel_clk_in),
        .rst  (rst_in),
        .din  (win),
        .dout (win_dly)
    );

    // Gate the BROM pixel with the aligned window bit and the blink phase.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= (win_dly && phase_q) ? sprite_pixel_in : 12'h000;
        end
    end

    assign sprite_sel_out   = state_q;
    assign screen_state_out = state_q;
    assign sprite_x_out     = 11'(SPRITE_X);
    assign sprite_y_out     = 10'(SPRITE_Y);
    assign filter_idx_out   = idx_q;
    assign filter_valid_out = valid_q;
    assign pixel_out        = pixel_q;

endmodule

// File: tb/tb_ui_screen_sequencer.sv
module tb_ui_screen_sequencer;

    localparam int LAT = 4;
    localparam int NF  = 4;
    localparam int BL  = 30;
    localparam int TO  = 600;
    localparam int SX  = 190;
    localparam int SW  = 900;
    localparam int SY  = 680;
    localparam int SH  = 24;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        new_frame_in = 1'b0;
    logic        btn_next = 1'b0, btn_back = 1'b0, btn_sel = 1'b0;
    logic [11:0] sprite_pixel_in = '0;
    logic [1:0]  sprite_sel_out;
    logic [10:0] sprite_x_out;
    logic [9:0]  sprite_y_out;
    logic [1:0]  screen_state_out;
    logic [1:0]  filter_idx_out;
    logic        filter_valid_out;
    logic [11:0] pixel_out;

    always #5 clk = ~clk;

    ui_screen_sequencer dut (
        .pixel_clk_in      (clk),
        .rst_in            (rst_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .new_frame_in      (new_frame_in),
        .btn_next_pulse_in (btn_next),
        .btn_back_pulse_in (btn_back),
        .btn_sel_pulse_in  (btn_sel),
        .sprite_pixel_in   (sprite_pixel_in),
        .sprite_sel_out    (sprite_sel_out),
        .sprite_x_out      (sprite_x_out),
        .sprite_y_out      (sprite_y_out),
        .screen_state_out  (screen_state_out),
        .filter_idx_out    (filter_idx_out),
        .filter_valid_out  (filter_valid_out),
        .pixel_out         (pixel_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: screen as an integer, dwell counted in whole frames
    // since entering CONFIRM, a 3-bit pressed-this-frame set, and a history
    // of window hits indexed by cycle number.
    int m_st, m_idx, m_k, m_pix, cyc, last_rst;
    bit m_valid;
    bit [2:0] m_pend;            // bit0 next, bit1 back, bit2 sel
    bit win_hist [8];
    int cur_h = 0, cur_v = 0;

    function automatic bit in_win(input int h, input int v);
        return (h >= SX) && (h < SX + SW) && (v >= SY) && (v < SY + SH);
    endfunction

    task automatic cycle(input bit r, input bit f, input bit pn, input bit pb,
                         input bit ps, input logic [11:0] px);
        bit ph;
        bit [2:0] p;
        int act;     // 0 none, 1 next, 2 back, 3 sel
        rst_in = r; new_frame_in = f;
        btn_next = pn; btn_back = pb; btn_sel = ps;
        hcount_in = 11'(cur_h); vcount_in = 10'(cur_v);
        sprite_pixel_in = px;
        @(posedge clk);
        ph = (m_st != 2) || (((m_k / BL) % 2) == 0);
        if (r) begin
            m_st = 0; m_idx = 0; m_valid = 0; m_pend = 3'b000; m_k = 0; m_pix = 0;
            last_rst = cyc;
        end else begin
            m_pix = ((cyc - LAT > last_rst) && win_hist[(cyc - LAT) % 8] && ph) ? int'(px) : 0;
            p = m_pend | {ps, pb, pn};
            if (f) begin
                act = p[1] ? 2 : p[2] ? 3 : p[0] ? 1 : 0;
                case (m_st)
                    0: if (act == 3) m_st = 1;
                    1: begin
                        if (act == 1) m_idx = (m_idx + 1) % NF;
                        else if (act == 2) m_idx = (m_idx + NF - 1) % NF;
                        else if (act == 3) begin m_st = 2; m_k = 0; end
                    end
                    2: begin
                        if (act == 3) m_st = 3;
                        else if (act == 2) m_st = 1;
                        else begin
                            m_k++;
                            if (m_k == TO) m_st = 1;
                        end
                    end
                    default: if (act == 2) m_st = 1;
                endcase
                m_pend = 3'b000;
            end else begin
                m_pend = p;
            end
            m_valid = (m_st == 3);
        end
        win_hist[cyc % 8] = in_win(cur_h, cur_v);
        cyc++;
        #1;
        chk("state", 32'(screen_state_out), 32'(m_st));
        chk("sprite_sel", 32'(sprite_sel_out), 32'(m_st));
        chk("filter_idx", 32'(filter_idx_out), 32'(m_idx));
        chk("filter_valid", 32'(filter_valid_out), 32'(m_valid));
        chk("pixel", 32'(pixel_out), 32'(m_pix));
        chk("sprite_xy", {5'd0, sprite_x_out, 6'd0, sprite_y_out}, {5'd0, 11'd190, 6'd0, 10'd680});
        btn_next = 0; btn_back = 0; btn_sel = 0; new_frame_in = 0;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 12'($urandom));
    endtask

    // Press mid-frame, then let the next frame start commit it.
    task automatic frame(input bit pn, input bit pb, input bit ps);
        cycle(0, 0, pn, pb, ps, 12'($urandom));
        plain(1);
        cycle(0, 1, 0, 0, 0, 12'($urandom));
    endtask

    int hv_h [8] = '{189, 190, 191, 640, 1089, 1090, 1091, 0};
    int hv_v [6] = '{679, 680, 690, 703, 704, 0};

    initial begin
        m_st = 0; m_idx = 0; m_valid = 0; m_pend = 0; m_k = 0; m_pix = 0;
        cyc = 0; last_rst = -1;
        for (int i = 0; i < 8; i++) win_hist[i] = 0;

        // Reset values
        repeat (3) cycle(1, 0, 0, 0, 0, 12'hFFF);
        chk("rst_state", 32'(screen_state_out), 0);
        chk("rst_pixel", 32'(pixel_out), 0);

        // TITLE -> FILTER_SELECT only at the frame edge
        cycle(0, 0, 0, 0, 1, 12'h123);
        plain(2);
        chk("no_early_commit", 32'(screen_state_out), 0);
        cycle(0, 1, 0, 0, 0, 12'h123);
        chk("title_to_fs", 32'(screen_state_out), 1);
        chk("fs_idx0", 32'(filter_idx_out), 0);

        // Index wrap both ways, back beats next
        frame(0, 1, 0);  chk("back_wrap", 32'(filter_idx_out), 3);
        frame(1, 0, 0);  chk("next_wrap", 32'(filter_idx_out), 0);
        frame(1, 0, 0);  chk("next_step", 32'(filter_idx_out), 1);
        frame(1, 1, 0);  chk("back_prio", 32'(filter_idx_out), 0);
        frame(1, 0, 0);  chk("next_again", 32'(filter_idx_out), 1);

        // CONFIRM -> RUN, idx frozen, back out of RUN
        frame(0, 0, 1);  chk("to_confirm", 32'(screen_state_out), 2);
        chk("confirm_not_valid", 32'(filter_valid_out), 0);
        frame(0, 0, 1);  chk("to_run", 32'(screen_state_out), 3);
        chk("run_valid", 32'(filter_valid_out), 1);
        frame(1, 0, 1);  chk("run_idx_frozen", 32'(filter_idx_out), 1);
        chk("run_ignores_sel", 32'(screen_state_out), 3);
        frame(0, 1, 0);  chk("run_back", 32'(screen_state_out), 1);
        chk("run_back_valid", 32'(filter_valid_out), 0);

        // Pixel latency and horizontal window edges
        cur_h = 190; cur_v = 680; cycle(0, 0, 0, 0, 0, 12'h111);
        cur_h = 0; cur_v = 0;
        repeat (3) cycle(0, 0, 0, 0, 0, 12'h222);
        cycle(0, 0, 0, 0, 0, 12'hABC);
        chk("pix_latency", 32'(pixel_out), 32'h0ABC);
        cur_h = 189; cur_v = 680; cycle(0, 0, 0, 0, 0, 12'h111);
        cur_h = 0; repeat (4) cycle(0, 0, 0, 0, 0, 12'hFFF);
        chk("pix_left_edge", 32'(pixel_out), 0);
        cur_h = 1090; cur_v = 690; cycle(0, 0, 0, 0, 0, 12'h111);
        cur_h = 0; repeat (4) cycle(0, 0, 0, 0, 0, 12'hFFF);
        chk("pix_right_edge", 32'(pixel_out), 0);
        cur_h = 1089; cur_v = 703; cycle(0, 0, 0, 0, 0, 12'h111);
        cur_h = 0; repeat (4) cycle(0, 0, 0, 0, 0, 12'h5A5);
        chk("pix_last_inside", 32'(pixel_out), 32'h05A5);

        // CONFIRM blink and timeout, sprite window held on screen
        cur_h = 600; cur_v = 690;
        frame(0, 0, 1);
        for (int i = 1; i < TO; i++) begin
            plain(1);
            cycle(0, 1, 0, 0, 0, 12'($urandom));
            if (i == 30) begin
                repeat (6) cycle(0, 0, 0, 0, 0, 12'h5A5);
                chk("blink_off", 32'(pixel_out), 0);
            end
            if (i == 60) begin
                repeat (6) cycle(0, 0, 0, 0, 0, 12'h5A5);
                chk("blink_on", 32'(pixel_out), 32'h05A5);
            end
        end
        chk("timeout_not_yet", 32'(screen_state_out), 2);
        plain(1);
        cycle(0, 1, 0, 0, 0, 12'($urandom));
        chk("timeout_exit", 32'(screen_state_out), 1);

        // Reset in RUN with a press pending; the press must not survive
        frame(0, 0, 1);
        frame(0, 0, 1);
        chk("run_again", 32'(screen_state_out), 3);
        cycle(0, 0, 0, 0, 1, 12'h777);
        cycle(1, 0, 0, 0, 0, 12'h777);
        chk("rst_run_state", 32'(screen_state_out), 0);
        chk("rst_run_valid", 32'(filter_valid_out), 0);
        chk("rst_run_pixel", 32'(pixel_out), 0);
        cycle(0, 1, 0, 0, 0, 12'h777);
        chk("pend_discarded", 32'(screen_state_out), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cur_h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : hv_h[$urandom_range(0, 7)];
            cur_v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : hv_v[$urandom_range(0, 5)];
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 6) == 0),
                  12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
